// File: rtl/selfadd_pkg.sv
// -----------------------------------------------------------------------------
// selfadd_pkg
// Shared definitions for the self-add accumulator array:
//   - mode encodings for the SIGNED and SAT parameters
//   - cnt_w(): width of the per-window beat counter
//   - clamp bounds for saturating arithmetic, as functions of the lane width.
//     Each bound is returned as a 64-bit pattern. The caller truncates it to W
//     bits, so the signed minimum is the plain 100..0 bit pattern.
// -----------------------------------------------------------------------------
package selfadd_pkg;

  localparam int SELFADD_WRAP     = 0;
  localparam int SELFADD_SAT      = 1;
  localparam int SELFADD_UNSIGNED = 0;
  localparam int SELFADD_SIGNED   = 1;

  // The counter must be able to hold LOOP-1. It is sized for LOOP+1 so that
  // LOOP=1 still gets a 1-bit counter.
  function automatic int cnt_w(input int loop);
    return (loop < 1) ? 1 : $clog2(loop + 1);
  endfunction

  function automatic logic [63:0] sat_umax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_umin(input int w);
    return 64'd0 & 64'(w);
  endfunction

  function automatic logic [63:0] sat_smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_smin(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/selfadd_lane_acc.sv
// -----------------------------------------------------------------------------
// selfadd_lane_acc
// One accumulator lane. It holds the adder with its optional clamp, the
// running sum, the sticky overflow and the registered lane output.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-low reset
//   i_clr   - restart the window (already gated by halt in the top)
//   i_step  - add i_data this cycle (already gated by halt/clear in the top)
//   i_last  - this step completes the window
//   i_data  - lane operand from stage S1
//   o_data  - completed window sum
//   o_ovf   - overflow seen anywhere in the reported window
// -----------------------------------------------------------------------------
module selfadd_lane_acc
  import selfadd_pkg::*;
#(
  parameter int W      = 16,
  parameter int SIGNED = SELFADD_UNSIGNED,
  parameter int SAT    = SELFADD_WRAP
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_step,
  input  logic         i_last,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_ovf
);

  localparam bit           L_SIGNED = (SIGNED == SELFADD_SIGNED);
  localparam bit           L_SAT    = (SAT == SELFADD_SAT);
  localparam logic [W-1:0] L_UMAX   = W'(sat_umax(W));
  localparam logic [W-1:0] L_SMAX   = W'(sat_smax(W));
  localparam logic [W-1:0] L_SMIN   = W'(sat_smin(W));

  logic [W-1:0] r_acc;
  logic         r_sticky;
  logic [W-1:0] r_outData;
  logic         r_outOvf;

  logic [W:0]   w_extAcc;
  logic [W:0]   w_extIn;
  logic [W:0]   w_sum;
  logic         w_stepOvf;
  logic [W-1:0] w_result;

  // The sum is formed one bit wider than the lane. In signed mode bit W is
  // the true sign of the result. Signed overflow is therefore the top two
  // bits disagreeing, and that same true sign chooses which bound to clamp to.
  // Unsigned addition can only run past the top, so only the upper bound is
  // ever reached.
  always_comb begin
    if (L_SIGNED) begin
      w_extAcc = {r_acc[W-1], r_acc};
      w_extIn  = {i_data[W-1], i_data};
    end else begin
      w_extAcc = {1'b0, r_acc};
      w_extIn  = {1'b0, i_data};
    end
    w_sum     = w_extAcc + w_extIn;
    w_stepOvf = L_SIGNED ? (w_sum[W] ^ w_sum[W-1]) : w_sum[W];
    w_result  = w_sum[W-1:0];
    if (L_SAT && w_stepOvf) begin
      if (!L_SIGNED) begin
        w_result = L_UMAX;
      end else if (w_sum[W]) begin
        w_result = L_SMIN;
      end else begin
        w_result = L_SMAX;
      end
    end
  end

  // On the last beat the sum goes straight to the output register and the
  // accumulator restarts from zero. The next window can then begin on the
  // very next step.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_acc     <= '0;
      r_sticky  <= 1'b0;
      r_outData <= '0;
      r_outOvf  <= 1'b0;
    end else if (i_clr) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
    end else if (i_step) begin
      if (i_last) begin
        r_outData <= w_result;
        r_outOvf  <= r_sticky | w_stepOvf;
        r_acc     <= '0;
        r_sticky  <= 1'b0;
      end else begin
        r_acc    <= w_result;
        r_sticky <= r_sticky | w_stepOvf;
      end
    end
  end

  assign o_data = r_outData;
  assign o_ovf  = r_outOvf;

endmodule

// File: rtl/selfadd_acc_array.sv
// -----------------------------------------------------------------------------
// selfadd_acc_array
// LANES independent W-bit accumulators. Each one sums every LOOP valid beats
// and presents the sum together with a one-cycle o_out_v.
// Ports:
//   i_clk      - clock, rising edge
//   i_rst      - synchronous active-low reset
//   i_data_v   - i_in_data valid this cycle
//   i_in_data  - lane i in bits [i*W +: W]
//   i_usr_clr  - restart the accumulation window
//   i_halt     - freeze all state
//   o_out_data - completed sums, same packing as i_in_data
//   o_out_v    - o_out_data holds a new sum
//   o_out_ovf  - per-lane overflow within the reported window
// -----------------------------------------------------------------------------
module selfadd_acc_array
  import selfadd_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int W      = 16,
  parameter int LOOP   = 3,
  parameter int SIGNED = SELFADD_UNSIGNED,
  parameter int SAT    = SELFADD_WRAP
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_data_v,
  input  logic [LANES*W-1:0] i_in_data,
  input  logic               i_usr_clr,
  input  logic               i_halt,
  output logic [LANES*W-1:0] o_out_data,
  output logic               o_out_v,
  output logic [LANES-1:0]   o_out_ovf
);

  localparam int            CW     = cnt_w(LOOP);
  localparam logic [CW-1:0] L_LAST = CW'(LOOP - 1);

  logic               r_s1Valid;
  logic [LANES*W-1:0] r_s1Data;
  logic [CW-1:0]      r_beatCnt;
  logic               r_outV;

  logic w_clr;
  logic w_step;
  logic w_last;

  // A clear in the same cycle drops the beat that is waiting in S1.
  // Halt blocks every change of state.
  assign w_clr  = i_usr_clr & ~i_halt;
  assign w_step = r_s1Valid & ~i_halt & ~i_usr_clr;
  assign w_last = (r_beatCnt == L_LAST);

  // S1 capture, beat counting and the output-valid pulse. S1 reloads even
  // when a clear is applied, so a beat that arrives with the clear becomes
  // beat 0 of the new window.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_beatCnt <= '0;
      r_outV    <= 1'b0;
    end else if (!i_halt) begin
      r_s1Valid <= i_data_v;
      if (i_data_v) begin
        r_s1Data <= i_in_data;
      end
      r_outV <= 1'b0;
      if (i_usr_clr) begin
        r_beatCnt <= '0;
      end else if (r_s1Valid) begin
        if (w_last) begin
          r_beatCnt <= '0;
          r_outV    <= 1'b1;
        end else begin
          r_beatCnt <= r_beatCnt + CW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    selfadd_lane_acc #(
      .W      (W),
      .SIGNED (SIGNED),
      .SAT    (SAT)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_clr),
      .i_step (w_step),
      .i_last (w_last),
      .i_data (r_s1Data[g*W +: W]),
      .o_data (o_out_data[g*W +: W]),
      .o_ovf  (o_out_ovf[g])
    );
  end

  assign o_out_v = r_outV;

endmodule

// File: tb/tb_selfadd_acc_array.sv
// -----------------------------------------------------------------------------
// tb_selfadd_acc_array
// Four instances of selfadd_acc_array are driven from the same inputs:
//   0: LANES=2 LOOP=3 unsigned wrap
//   1: LANES=1 LOOP=3 signed saturating
//   2: LANES=1 LOOP=3 signed wrap
//   3: LANES=4 LOOP=1 unsigned wrap
// A window model built from integer arithmetic predicts every output on every
// cycle. Literal expectations for the individual scenarios pin that model down.
// -----------------------------------------------------------------------------
module tb_selfadd_acc_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        dataV;
  logic        usrClr;
  logic        halt;
  logic [63:0] inData;

  logic [31:0] dataA;  logic vA;  logic [1:0] ovfA;
  logic [15:0] dataB;  logic vB;  logic [0:0] ovfB;
  logic [15:0] dataC;  logic vC;  logic [0:0] ovfC;
  logic [63:0] dataD;  logic vD;  logic [3:0] ovfD;

  logic [63:0] dutData[4];
  logic        dutV[4];
  logic [3:0]  dutOvf[4];

  int total = 0;
  int bad   = 0;

  bit          modelValid = 1'b0;
  bit          edgeHalted = 1'b0;
  bit          pendValid[4];
  logic [63:0] pendData[4];
  int          winCnt[4];
  int          win[4][4][3];
  logic [15:0] expData[4][4];
  bit          expOvf[4][4];
  bit          expV[4];

  int obsData[4][$];
  int obsOvf[4][$];

  logic [63:0] t6Vals[6];
  int          t6Lane0[6];

  always #5 clk = ~clk;

  selfadd_acc_array #(.LANES(2), .W(16), .LOOP(3), .SIGNED(0), .SAT(0)) dutA (
    .i_clk(clk), .i_rst(rst), .i_data_v(dataV), .i_in_data(inData[31:0]),
    .i_usr_clr(usrClr), .i_halt(halt),
    .o_out_data(dataA), .o_out_v(vA), .o_out_ovf(ovfA));

  selfadd_acc_array #(.LANES(1), .W(16), .LOOP(3), .SIGNED(1), .SAT(1)) dutB (
    .i_clk(clk), .i_rst(rst), .i_data_v(dataV), .i_in_data(inData[15:0]),
    .i_usr_clr(usrClr), .i_halt(halt),
    .o_out_data(dataB), .o_out_v(vB), .o_out_ovf(ovfB));

  selfadd_acc_array #(.LANES(1), .W(16), .LOOP(3), .SIGNED(1), .SAT(0)) dutC (
    .i_clk(clk), .i_rst(rst), .i_data_v(dataV), .i_in_data(inData[15:0]),
    .i_usr_clr(usrClr), .i_halt(halt),
    .o_out_data(dataC), .o_out_v(vC), .o_out_ovf(ovfC));

  selfadd_acc_array #(.LANES(4), .W(16), .LOOP(1), .SIGNED(0), .SAT(0)) dutD (
    .i_clk(clk), .i_rst(rst), .i_data_v(dataV), .i_in_data(inData),
    .i_usr_clr(usrClr), .i_halt(halt),
    .o_out_data(dataD), .o_out_v(vD), .o_out_ovf(ovfD));

  assign dutData[0] = {32'd0, dataA};
  assign dutData[1] = {48'd0, dataB};
  assign dutData[2] = {48'd0, dataC};
  assign dutData[3] = dataD;
  assign dutV[0]    = vA;
  assign dutV[1]    = vB;
  assign dutV[2]    = vC;
  assign dutV[3]    = vD;
  assign dutOvf[0]  = {2'd0, ovfA};
  assign dutOvf[1]  = {3'd0, ovfB};
  assign dutOvf[2]  = {3'd0, ovfC};
  assign dutOvf[3]  = ovfD;

  // Per-instance configuration
  function automatic int cfgLanes(input int d);
    case (d)
      0:       return 2;
      1, 2:    return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int cfgLoop(input int d);
    return (d == 3) ? 1 : 3;
  endfunction

  function automatic bit cfgSigned(input int d);
    return (d == 1) || (d == 2);
  endfunction

  function automatic bit cfgSat(input int d);
    return (d == 1);
  endfunction

  // Sum one lane's window beat by beat, using plain integers for the
  // overflow, clamp and wrap rules
  function automatic int foldLane(input int d, input int l, output bit ovf);
    longint run, x, lo, hi;
    run = 0;
    ovf = 1'b0;
    if (cfgSigned(d)) begin lo = -32768; hi = 32767; end
    else begin lo = 0; hi = 65535; end
    for (int b = 0; b < cfgLoop(d); b++) begin
      x = longint'(win[d][l][b]);
      if (cfgSigned(d) && x >= 32768) x = x - 65536;
      run = run + x;
      if (run > hi || run < lo) begin
        ovf = 1'b1;
        if (cfgSat(d)) begin
          run = (run > hi) ? hi : lo;
        end else begin
          run = run & 64'hFFFF;
          if (cfgSigned(d) && run >= 32768) run = run - 65536;
        end
      end
    end
    return int'(run & 64'hFFFF);
  endfunction

  // Model update for one rising edge, using the inputs that edge samples
  task automatic modelStep();
    bit o;
    edgeHalted = 1'b0;
    if (!rst) begin
      modelValid = 1'b1;
      for (int d = 0; d < 4; d++) begin
        pendValid[d] = 1'b0;
        winCnt[d]    = 0;
        expV[d]      = 1'b0;
        for (int l = 0; l < 4; l++) begin
          expData[d][l] = 16'd0;
          expOvf[d][l]  = 1'b0;
        end
      end
    end else if (halt) begin
      edgeHalted = 1'b1;
    end else begin
      for (int d = 0; d < 4; d++) begin
        expV[d] = 1'b0;
        if (usrClr) begin
          winCnt[d] = 0;
        end else if (pendValid[d]) begin
          for (int l = 0; l < cfgLanes(d); l++)
            win[d][l][winCnt[d]] = int'(pendData[d][l*16 +: 16]);
          winCnt[d]++;
          if (winCnt[d] == cfgLoop(d)) begin
            for (int l = 0; l < cfgLanes(d); l++) begin
              expData[d][l] = 16'(foldLane(d, l, o));
              expOvf[d][l]  = o;
            end
            expV[d]   = 1'b1;
            winCnt[d] = 0;
          end
        end
        pendValid[d] = dataV;
        pendData[d]  = inData;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compareAll();
    if (!modelValid) return;
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("d%0d_out_v", d), 64'(dutV[d]), 64'(expV[d]));
      for (int l = 0; l < cfgLanes(d); l++) begin
        checkOutput($sformatf("d%0d_l%0d_data", d, l), 64'(dutData[d][l*16 +: 16]), 64'(expData[d][l]));
        checkOutput($sformatf("d%0d_l%0d_ovf", d, l), 64'(dutOvf[d][l]), 64'(expOvf[d][l]));
      end
      if (dutV[d] === 1'b1 && !edgeHalted) begin
        obsData[d].push_back(int'(dutData[d][15:0]));
        obsOvf[d].push_back(int'(dutOvf[d][0]));
      end
    end
  endtask

  function automatic int obsAt(input int d, input int k);
    return (k < obsData[d].size()) ? obsData[d][k] : -1;
  endfunction

  function automatic int ovfAt(input int d, input int k);
    return (k < obsOvf[d].size()) ? obsOvf[d][k] : -1;
  endfunction

  task automatic clearObs();
    for (int d = 0; d < 4; d++) begin
      obsData[d].delete();
      obsOvf[d].delete();
    end
  endtask

  // Drive one cycle of inputs, starting at a falling edge
  task automatic applyStimulus(input logic r, input logic dv, input logic [63:0] d,
                               input logic clr, input logic h);
    @(negedge clk);
    rst    = r;
    dataV  = dv;
    inData = d;
    usrClr = clr;
    halt   = h;
  endtask

  task automatic beat(input logic [63:0] d);
    applyStimulus(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  // The model advances on each rising edge
  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // The compare process checks every instance on each falling edge
  initial forever begin
    @(negedge clk);
    compareAll();
  end

  initial begin
    rst = 1'b0; dataV = 1'b0; usrClr = 1'b0; halt = 1'b0; inData = 64'd0;
    t6Vals  = '{64'h0004_0003_0002_0001, 64'hFFFF_8000_1234_ABCD, 64'h0000_0000_0000_0000,
                64'h7FFF_0001_FFFE_5555, 64'hDEAD_BEEF_CAFE_0F0F, 64'h1111_2222_3333_4444};
    t6Lane0 = '{32'h0001, 32'hABCD, 32'h0000, 32'h5555, 32'h0F0F, 32'h4444};

    // Reset state
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    checkOutput("reset_out_v", 64'(vA), 64'd0);
    checkOutput("reset_out_data", 64'(dataA), 64'd0);
    checkOutput("reset_out_ovf", 64'(ovfA), 64'd0);

    // Back-to-back windows, then an unsigned wrap
    clearObs();
    for (int k = 1; k <= 6; k++) beat({32'd0, 16'(10 * k), 16'(k)});
    beat(64'h0000_FFFF);
    beat(64'h0000_0002);
    beat(64'h0000_0001);
    idle(3);
    checkOutput("t1_count", 64'(obsData[0].size()), 64'd3);
    checkOutput("t1_sum0", 64'(obsAt(0, 0)), 64'd6);
    checkOutput("t1_ovf0", 64'(ovfAt(0, 0)), 64'd0);
    checkOutput("t1_sum1", 64'(obsAt(0, 1)), 64'd15);
    checkOutput("t1_wrap_sum", 64'(obsAt(0, 2)), 64'd2);
    checkOutput("t1_wrap_ovf", 64'(ovfAt(0, 2)), 64'd1);

    // Signed saturation versus signed wrap
    clearObs();
    beat(64'h7000);
    beat(64'h7000);
    beat(64'h0001);
    idle(3);
    checkOutput("t2_sat_sum", 64'(obsAt(1, 0)), 64'h7FFF);
    checkOutput("t2_sat_ovf", 64'(ovfAt(1, 0)), 64'd1);
    checkOutput("t2_wrap_sum", 64'(obsAt(2, 0)), 64'hE001);
    checkOutput("t2_wrap_ovf", 64'(ovfAt(2, 0)), 64'd1);
    checkOutput("t2_uns_sum", 64'(obsAt(0, 0)), 64'hE001);

    // Halt holds a raised out_v, then halt in the middle of a window
    clearObs();
    beat(64'd1); beat(64'd1); beat(64'd1);
    idle(1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    checkOutput("t3_hold_v", 64'(vA), 64'd1);
    checkOutput("t3_hold_sum", 64'(dataA[15:0]), 64'd3);
    beat(64'd10);
    beat(64'd20);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    beat(64'd30);
    idle(3);
    checkOutput("t3_count", 64'(obsData[0].size()), 64'd2);
    checkOutput("t3_sum_pre", 64'(obsAt(0, 0)), 64'd3);
    checkOutput("t3_sum_halt", 64'(obsAt(0, 1)), 64'd60);

    // A user clear that arrives with a beat starts a new window
    clearObs();
    beat(64'd5);
    beat(64'd7);
    applyStimulus(1'b1, 1'b1, 64'd1, 1'b1, 1'b0);
    beat(64'd2);
    beat(64'd3);
    idle(3);
    checkOutput("t4_count", 64'(obsData[0].size()), 64'd1);
    checkOutput("t4_sum", 64'(obsAt(0, 0)), 64'd6);

    // Reset in the middle of a window, also asserted together with halt
    clearObs();
    beat(64'd9);
    beat(64'd9);
    applyStimulus(1'b0, 1'b1, 64'd9, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    checkOutput("t5_rst_v", 64'(vA), 64'd0);
    checkOutput("t5_rst_data", 64'(dataA), 64'd0);
    checkOutput("t5_rst_ovf", 64'(ovfC), 64'd0);
    checkOutput("t5_rst_dataC", 64'(dataC), 64'd0);
    beat(64'd1); beat(64'd1); beat(64'd1);
    idle(3);
    checkOutput("t5_count", 64'(obsData[0].size()), 64'd1);
    checkOutput("t5_sum", 64'(obsAt(0, 0)), 64'd3);

    // LOOP=1 pass-through stream
    clearObs();
    beat(t6Vals[0]);
    beat(t6Vals[1]);
    @(posedge clk);
    #1;
    checkOutput("t6_latency_v", 64'(vD), 64'd1);
    checkOutput("t6_latency_data", dataD, t6Vals[0]);
    for (int k = 2; k < 6; k++) beat(t6Vals[k]);
    idle(3);
    checkOutput("t6_count", 64'(obsData[3].size()), 64'd6);
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("t6_lane0_%0d", k), 64'(obsAt(3, k)), 64'(t6Lane0[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/selfadd_acc_array.md
# selfadd_acc_array

Parametrised successor to the two-lane self-add register pair: `LANES` independent `W`-bit accumulators that sum every `LOOP` consecutive valid input beats. Each completed sum is presented with a one-cycle `out_v`. It adds optional signed and saturating arithmetic, a per-lane overflow flag, a user clear and a halt freeze. It sits between a streaming producer and the downstream reg-heap and reduction stages, and replaces fixed-width, fixed-loop self-add units.

## Interface
- `LANES`, default 2: number of independent accumulator lanes, ≥1.
- `W`, default 16: lane data and accumulator width, ≥2.
- `LOOP`, default 3: beats summed per output, ≥1; the beat counter is `$clog2(LOOP+1)` bits.
- `SIGNED`, default 0: 1 = two's-complement lanes, 0 = unsigned.
- `SAT`, default 0: 1 = clamp at each step, 0 = modulo-2^W wrap.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset; **synchronous, active-low**.
- `data_v`, input, 1: `in_data` valid this cycle.
- `in_data`, input, `LANES*W`: lane i occupies bits `[i*W +: W]`.
- `usr_clr`, input, 1: restart the accumulation window.
- `halt`, input, 1: freeze all state.
- `out_data`, output, `LANES*W`: completed sums, same lane packing as `in_data`.
- `out_v`, output, 1: `out_data` holds a new sum.
- `out_ovf`, output, `LANES`: lane saturated or wrapped in the reported window.

## Operation
- Stage S1: on a clock edge with `data_v=1` and `halt=0`, the input is registered together with a valid bit.
- Stage S2: when the S1 valid bit is set, `acc[i] <= acc[i] + s1[i]` and the beat counter increments.
- Last beat (counter reaches `LOOP-1`):
  - `out_data[i] <= acc[i] + s1[i]` and `out_v <= 1`.
  - `out_ovf[i]` is loaded from the window's sticky overflow OR this step's overflow.
  - `acc`, counter and sticky overflow reset to 0, so back-to-back windows need no gap.
- `out_v` is 0 on every other unhalted edge. `out_data` and `out_ovf` hold their last values.
- Arithmetic uses a W+1-bit intermediate.
  - SAT=0: truncate to W bits. Overflow = carry out (unsigned) or sign overflow (signed).
  - SAT=1: clamp to 2^W−1 / 0 (unsigned) or to 2^(W−1)−1 / −2^(W−1) (signed). Overflow = clamp taken.
- `LOOP=1`: every beat is passed straight through, `out_v` follows each beat, and `acc` stays 0.
- `usr_clr=1` with `halt=0`:
  - Clears `acc`, the counter, the sticky overflow and the S1 valid bit (the in-flight beat is discarded).
  - Drives `out_v` to 0.
  - A `data_v` beat in the same cycle is captured into S1 as beat 0 of the new window.
- `halt=1`:
  - Every register holds, `out_v` included; `data_v` and `usr_clr` are ignored.
  - A beat presented during halt is lost; producers must hold `data_v` low while `halt` is high.
- Reset state (`rst=0` on an edge): `out_data`=0, `out_v`=0, `out_ovf`=0. `acc`, counter, S1 and sticky overflow are all 0. Reset overrides `halt` and `usr_clr`.

## Timing
- Latency: last beat sampled on edge E, `out_v` high after edge E+1, which is 2 cycles from presentation. Halted cycles extend this 1:1.
- Throughput: one beat per cycle sustained; one output every `LOOP` accepted beats.
- No backpressure; `out_v` is not acknowledged.
- Reset mid-window: the partial sum is discarded and the first beat after reset release starts a new window.
- `usr_clr` on the same edge that S2 would complete a window: the clear wins, no `out_v` is produced and the sum is lost.

## Structure
- Shared package `selfadd_pkg` holds:
  - localparams for the mode encodings (`SELFADD_WRAP`/`SELFADD_SAT`, `SELFADD_UNSIGNED`/`SELFADD_SIGNED`);
  - the function `cnt_w(LOOP)`;
  - the signed and unsigned clamp bounds as functions of `W`.
- Sub-module `selfadd_lane_acc` contains one lane's adder, clamp, accumulator, sticky overflow and output register. It is instantiated `LANES` times under generate.
- The top level owns S1, the beat counter and the `halt`/`usr_clr`/`out_v` control.

## Test plan
- LANES=2, W=16, LOOP=3, unsigned wrap; beats lane0 = 1,2,3, then 4,5,6 back-to-back → `out_v` pulses 2 cycles after beats 3 and 6; lane0 = 6 then 15.
- W=16, SAT=1, SIGNED=1; lane0 beats 0x7000, 0x7000, 0x0001 → `out_data`=0x7FFF, `out_ovf[0]`=1. Same beats with SAT=0 → 0xE001, `out_ovf[0]`=1.
- LOOP=3; beats 10, 20, then `halt` for 4 cycles, then 30 → sum 60. All registers, including a prior `out_v`=1, hold through the halt.
- LOOP=3; beats 5, 7, then `usr_clr` together with beat 1, then beats 2, 3 → single `out_v` with sum 6.
- `rst`=0 asserted after 2 beats of a window → all outputs 0. Beats 1, 1, 1 after release → sum 3.
- LOOP=1, LANES=4; a continuous beat stream → `out_data` equals each input delayed 2 cycles, with `out_v` high for every beat.
